// File: rtl/cache_axi_port_mux_pkg.sv
// Shared types for the cache AXI port mux: channel structs and ID prefix helpers.
// Upstream IDs are CacheIdWidthIn wide; downstream IDs carry the master index in their MSBs.
package cache_axi_port_mux_pkg;
  localparam int unsigned CacheNumMst     = 3;
  localparam int unsigned CacheIdWidthIn  = 4;
  localparam int unsigned MstIdxWidth     = $clog2(CacheNumMst);
  localparam int unsigned CacheIdWidthOut = CacheIdWidthIn + MstIdxWidth;
  localparam int unsigned AxiAddrWidth    = 32;
  localparam int unsigned AxiDataWidth    = 32;

  typedef logic [MstIdxWidth-1:0] w_sel_t;

  typedef struct packed {
    logic [CacheIdWidthIn-1:0] id;
    logic [AxiAddrWidth-1:0]   addr;
    logic [7:0]                len;
  } mst_ar_chan_t;
  typedef mst_ar_chan_t mst_aw_chan_t;

  typedef struct packed {
    logic [CacheIdWidthOut-1:0] id;
    logic [AxiAddrWidth-1:0]    addr;
    logic [7:0]                 len;
  } slv_ar_chan_t;
  typedef slv_ar_chan_t slv_aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    logic [CacheIdWidthIn-1:0] id;
    logic [AxiDataWidth-1:0]   data;
    logic [1:0]                resp;
    logic                      last;
  } mst_r_chan_t;

  typedef struct packed {
    logic [CacheIdWidthOut-1:0] id;
    logic [AxiDataWidth-1:0]    data;
    logic [1:0]                 resp;
    logic                       last;
  } slv_r_chan_t;

  typedef struct packed {
    logic [CacheIdWidthIn-1:0] id;
    logic [1:0]                resp;
  } mst_b_chan_t;

  typedef struct packed {
    logic [CacheIdWidthOut-1:0] id;
    logic [1:0]                 resp;
  } slv_b_chan_t;

  typedef struct packed {
    mst_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    mst_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } mst_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    mst_b_chan_t b;
    logic        r_valid;
    mst_r_chan_t r;
  } mst_resp_t;

  typedef struct packed {
    slv_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    slv_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } slv_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    slv_b_chan_t b;
    logic        r_valid;
    slv_r_chan_t r;
  } slv_resp_t;

  function automatic w_sel_t id_prefix(input logic [CacheIdWidthOut-1:0] id);
    return id[CacheIdWidthOut-1 -: MstIdxWidth];
  endfunction
endpackage

// File: rtl/cache_axi_port_mux_rr_arb.sv
// Round-robin stream arbiter; the grant is held from the first cycle valid_o
// is high until the downstream handshake, so the selected payload stays put.
module cache_axi_rr_arb #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o,
  output logic [N-1:0]    gnt_o
);
  logic [IdxW-1:0] rr_q, lock_idx_q, pick;
  logic            locked_q, found;
  int unsigned     cand;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(rr_q) + i) % N;
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IdxW-1:0];
      end
    end
    valid_o = locked_q | found;
    idx_o   = locked_q ? lock_idx_q : pick;
    gnt_o   = valid_o ? (N'(1) << idx_o) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
    end else if (valid_o && ready_i) begin
      rr_q     <= (idx_o == IdxW'(N-1)) ? '0 : idx_o + 1'b1;
      locked_q <= 1'b0;
    end else if (valid_o) begin
      locked_q   <= 1'b1;
      lock_idx_q <= idx_o;
    end
  end
endmodule

// File: rtl/cache_axi_port_mux.sv
// N-master to 1-slave AXI4 mux: prefix-tagged IDs, RR AR/AW arbitration,
// AW-ordered W routing and per-master outstanding limits.
module cache_axi_port_mux
  import cache_axi_port_mux_pkg::*;
#(
  parameter int unsigned WFifoDepth = 4,
  parameter int unsigned MaxRdTxns  = 4,
  parameter int unsigned MaxWrTxns  = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  mst_req_t  mst_req_i  [CacheNumMst],
  output mst_resp_t mst_resp_o [CacheNumMst],
  output slv_req_t  slv_req_o,
  input  slv_resp_t slv_resp_i,
  output logic      route_err_o
);
  localparam int unsigned NumMst = CacheNumMst;
  localparam int unsigned RdCntW = $clog2(MaxRdTxns + 1);
  localparam int unsigned WrCntW = $clog2(MaxWrTxns + 1);
  localparam int unsigned PtrW   = (WFifoDepth > 1) ? $clog2(WFifoDepth) : 1;
  localparam int unsigned QCntW  = $clog2(WFifoDepth + 1);

  logic [NumMst-1:0] ar_req, aw_req, ar_gnt, aw_gnt;
  logic [NumMst-1:0] rd_inc, rd_dec, wr_inc, wr_dec;
  logic              ar_valid, aw_valid;
  w_sel_t            ar_idx, aw_idx, r_pre, b_pre;
  logic              r_oor, b_oor, route_err_q;
  logic [RdCntW-1:0] rd_cnt [NumMst];
  logic [WrCntW-1:0] wr_cnt [NumMst];

  w_sel_t            wq_mem [WFifoDepth];
  logic [PtrW-1:0]   wq_wptr, wq_rptr;
  logic [QCntW-1:0]  wq_cnt;
  logic              wq_full, wq_empty, wq_push, wq_pop;
  w_sel_t            wq_head;

  assign wq_full  = (wq_cnt == QCntW'(WFifoDepth));
  assign wq_empty = (wq_cnt == '0);
  assign wq_head  = wq_mem[wq_rptr];
  assign wq_push  = aw_valid & slv_resp_i.aw_ready;
  assign wq_pop   = slv_req_o.w_valid & slv_resp_i.w_ready & slv_req_o.w.last;

  assign r_pre = id_prefix(slv_resp_i.r.id);
  assign b_pre = id_prefix(slv_resp_i.b.id);
  assign r_oor = 32'(r_pre) >= NumMst;
  assign b_oor = 32'(b_pre) >= NumMst;
  assign route_err_o = route_err_q;

  cache_axi_rr_arb #(.N(NumMst), .IdxW(MstIdxWidth)) i_ar_arb (
    .clk_i, .rst_i, .req_i(ar_req), .ready_i(slv_resp_i.ar_ready),
    .valid_o(ar_valid), .idx_o(ar_idx), .gnt_o(ar_gnt)
  );

  // A full W queue masks AW like a limit so the slave never sees an AW we cannot queue.
  cache_axi_rr_arb #(.N(NumMst), .IdxW(MstIdxWidth)) i_aw_arb (
    .clk_i, .rst_i, .req_i(aw_req), .ready_i(slv_resp_i.aw_ready),
    .valid_o(aw_valid), .idx_o(aw_idx), .gnt_o(aw_gnt)
  );

  always_comb begin
    slv_req_o          = '0;
    slv_req_o.ar_valid = ar_valid;
    slv_req_o.ar.id    = {ar_idx, mst_req_i[ar_idx].ar.id};
    slv_req_o.ar.addr  = mst_req_i[ar_idx].ar.addr;
    slv_req_o.ar.len   = mst_req_i[ar_idx].ar.len;
    slv_req_o.aw_valid = aw_valid;
    slv_req_o.aw.id    = {aw_idx, mst_req_i[aw_idx].aw.id};
    slv_req_o.aw.addr  = mst_req_i[aw_idx].aw.addr;
    slv_req_o.aw.len   = mst_req_i[aw_idx].aw.len;
    if (!wq_empty) begin
      slv_req_o.w_valid = mst_req_i[wq_head].w_valid;
      slv_req_o.w       = mst_req_i[wq_head].w;
    end
    slv_req_o.r_ready = r_oor;
    slv_req_o.b_ready = b_oor;
    for (int unsigned m = 0; m < NumMst; m++) begin
      mst_resp_o[m]          = '0;
      mst_resp_o[m].ar_ready = ar_gnt[m] & slv_resp_i.ar_ready;
      mst_resp_o[m].aw_ready = aw_gnt[m] & slv_resp_i.aw_ready;
      mst_resp_o[m].w_ready  = !wq_empty && (wq_head == w_sel_t'(m)) && slv_resp_i.w_ready;
      mst_resp_o[m].r.id     = slv_resp_i.r.id[CacheIdWidthIn-1:0];
      mst_resp_o[m].r.data   = slv_resp_i.r.data;
      mst_resp_o[m].r.resp   = slv_resp_i.r.resp;
      mst_resp_o[m].r.last   = slv_resp_i.r.last;
      mst_resp_o[m].r_valid  = slv_resp_i.r_valid && (r_pre == w_sel_t'(m));
      mst_resp_o[m].b.id     = slv_resp_i.b.id[CacheIdWidthIn-1:0];
      mst_resp_o[m].b.resp   = slv_resp_i.b.resp;
      mst_resp_o[m].b_valid  = slv_resp_i.b_valid && (b_pre == w_sel_t'(m));
      if (r_pre == w_sel_t'(m)) slv_req_o.r_ready = mst_req_i[m].r_ready;
      if (b_pre == w_sel_t'(m)) slv_req_o.b_ready = mst_req_i[m].b_ready;
    end
  end

  for (genvar m = 0; m < NumMst; m++) begin : g_mst
    assign ar_req[m] = mst_req_i[m].ar_valid && (rd_cnt[m] != RdCntW'(MaxRdTxns));
    assign aw_req[m] = mst_req_i[m].aw_valid && (wr_cnt[m] != WrCntW'(MaxWrTxns)) && !wq_full;
    assign rd_inc[m] = ar_valid & ar_gnt[m] & slv_resp_i.ar_ready;
    assign wr_inc[m] = aw_valid & aw_gnt[m] & slv_resp_i.aw_ready;
    assign rd_dec[m] = mst_resp_o[m].r_valid & mst_req_i[m].r_ready & slv_resp_i.r.last;
    assign wr_dec[m] = mst_resp_o[m].b_valid & mst_req_i[m].b_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rd_cnt[m] <= '0;
        wr_cnt[m] <= '0;
      end else begin
        if (rd_inc[m] && !rd_dec[m]) rd_cnt[m] <= rd_cnt[m] + 1'b1;
        else if (!rd_inc[m] && rd_dec[m] && rd_cnt[m] != '0) rd_cnt[m] <= rd_cnt[m] - 1'b1;
        if (wr_inc[m] && !wr_dec[m]) wr_cnt[m] <= wr_cnt[m] + 1'b1;
        else if (!wr_inc[m] && wr_dec[m] && wr_cnt[m] != '0) wr_cnt[m] <= wr_cnt[m] - 1'b1;
      end
    end

    a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rd_dec[m] && !rd_inc[m] && rd_cnt[m] == '0));
    a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(wr_dec[m] && !wr_inc[m] && wr_cnt[m] == '0));
  end

  always_ff @(posedge clk_i) begin
    if (wq_push) wq_mem[wq_wptr] <= aw_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wq_wptr     <= '0;
      wq_rptr     <= '0;
      wq_cnt      <= '0;
      route_err_q <= 1'b0;
    end else begin
      if (wq_push) wq_wptr <= (wq_wptr == PtrW'(WFifoDepth-1)) ? '0 : wq_wptr + 1'b1;
      if (wq_pop)  wq_rptr <= (wq_rptr == PtrW'(WFifoDepth-1)) ? '0 : wq_rptr + 1'b1;
      wq_cnt <= wq_cnt + QCntW'(wq_push) - QCntW'(wq_pop);
      if ((slv_resp_i.r_valid && r_oor) || (slv_resp_i.b_valid && b_oor)) route_err_q <= 1'b1;
    end
  end

  a_ar_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    slv_req_o.ar_valid && !slv_resp_i.ar_ready |=> slv_req_o.ar_valid && $stable(slv_req_o.ar));
  a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    slv_req_o.aw_valid && !slv_resp_i.aw_ready |=> slv_req_o.aw_valid && $stable(slv_req_o.aw));
  a_wq_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wq_push && !wq_pop && wq_full));
endmodule

// File: tb/tb_cache_axi_port_mux.sv
// Directed bench for cache_axi_port_mux: arbitration order, ID tagging,
// W ordering, outstanding limits, W queue backpressure and routing errors.
module tb_cache_axi_port_mux;
  import cache_axi_port_mux_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  mst_req_t  mst_req  [CacheNumMst];
  mst_resp_t mst_resp [CacheNumMst];
  slv_req_t  slv_req;
  slv_resp_t slv_resp;
  logic      route_err;
  int        errors = 0;
  int        checks = 0;

  always #5 clk = ~clk;

  cache_axi_port_mux #(.WFifoDepth(2), .MaxRdTxns(4), .MaxWrTxns(4)) dut (
    .clk_i(clk), .rst_i(rst), .mst_req_i(mst_req), .mst_resp_o(mst_resp),
    .slv_req_o(slv_req), .slv_resp_i(slv_resp), .route_err_o(route_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int m = 0; m < CacheNumMst; m++) begin
      mst_req[m] = '0;
      mst_req[m].r_ready = 1'b1;
      mst_req[m].b_ready = 1'b1;
    end
    mst_req[0].ar.id = 4'h5;  mst_req[0].aw.id = 4'h5;
    mst_req[1].ar.id = 4'hA;  mst_req[1].aw.id = 4'h1;
    mst_req[2].ar.id = 4'h3;  mst_req[2].aw.id = 4'h7;
    slv_resp = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [5:0] exp_ar_id [6];

  initial begin
    exp_ar_id = '{6'h05, 6'h1A, 6'h23, 6'h05, 6'h1A, 6'h23};
    clr();
    do_reset();

    // Idle after reset, including a stray W with no AW queued.
    mst_req[0].w_valid = 1'b1;
    mst_req[0].w.last  = 1'b1;
    slv_resp.w_ready   = 1'b1;
    @(negedge clk);
    chk("rst_ar_valid", 32'(slv_req.ar_valid), 0);
    chk("rst_aw_valid", 32'(slv_req.aw_valid), 0);
    chk("rst_w_valid", 32'(slv_req.w_valid), 0);
    chk("rst_m0_w_ready", 32'(mst_resp[0].w_ready), 0);
    chk("rst_m0_ar_ready", 32'(mst_resp[0].ar_ready), 0);
    chk("rst_m2_aw_ready", 32'(mst_resp[2].aw_ready), 0);
    chk("rst_route_err", 32'(route_err), 0);
    chk("rst_r_ready_pass", 32'(slv_req.r_ready), 1);
    chk("rst_b_ready_pass", 32'(slv_req.b_ready), 1);
    nxt();

    // Round-robin AR among three always-valid masters.
    clr();
    for (int m = 0; m < CacheNumMst; m++) mst_req[m].ar_valid = 1'b1;
    slv_resp.ar_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_ar_id", 32'(slv_req.ar.id), 32'(exp_ar_id[c]));
      chk("rr_winner_ready", 32'(mst_resp[c % 3].ar_ready), 1);
      nxt();
    end

    // Read limit on master 0.
    do_reset();
    mst_req[0].ar_valid = 1'b1;
    slv_resp.ar_ready   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lim_ar_id", 32'(slv_req.ar.id), 32'h05);
      nxt();
    end
    @(negedge clk);
    chk("lim_blocked", 32'(slv_req.ar_valid), 0);
    nxt();
    mst_req[1].ar_valid = 1'b1;
    @(negedge clk);
    chk("lim_m1_served", 32'(slv_req.ar.id), 32'h1A);
    chk("lim_m0_ready", 32'(mst_resp[0].ar_ready), 0);
    nxt();
    mst_req[1].ar_valid = 1'b0;
    mst_req[2].ar_valid = 1'b1;
    @(negedge clk);
    chk("lim_m2_served", 32'(slv_req.ar.id), 32'h23);
    nxt();
    mst_req[2].ar_valid = 1'b0;
    @(negedge clk);
    chk("lim_still_blocked", 32'(slv_req.ar_valid), 0);
    nxt();
    slv_resp.r_valid = 1'b1;
    slv_resp.r.id    = 6'h05;
    slv_resp.r.data  = 32'hCAFE0001;
    slv_resp.r.last  = 1'b1;
    @(negedge clk);
    chk("r_m0_valid", 32'(mst_resp[0].r_valid), 1);
    chk("r_m1_valid", 32'(mst_resp[1].r_valid), 0);
    chk("r_m0_id", 32'(mst_resp[0].r.id), 32'h5);
    chk("r_m0_data", mst_resp[0].r.data, 32'hCAFE0001);
    chk("r_same_cycle_blocked", 32'(slv_req.ar_valid), 0);
    nxt();
    slv_resp.r_valid = 1'b0;
    @(negedge clk);
    chk("lim_released", 32'(slv_req.ar_valid), 1);
    chk("lim_released_m0", 32'(mst_resp[0].ar_ready), 1);
    nxt();

    // W ordering: AW from master 2 (4 beats) then master 1 (1 beat).
    do_reset();
    slv_resp.aw_ready   = 1'b1;
    slv_resp.w_ready    = 1'b1;
    mst_req[2].aw_valid = 1'b1;
    mst_req[2].w_valid  = 1'b1;
    mst_req[2].w.data   = 32'h200;
    @(negedge clk);
    chk("wo_aw2_id", 32'(slv_req.aw.id), 32'h27);
    chk("wo_same_cycle_w", 32'(slv_req.w_valid), 0);
    nxt();
    mst_req[2].aw_valid = 1'b0;
    mst_req[1].aw_valid = 1'b1;
    mst_req[1].w_valid  = 1'b1;
    mst_req[1].w.data   = 32'h100;
    mst_req[1].w.last   = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mst_req[2].w.data = 32'h200 + 32'(b);
      mst_req[2].w.last = (b == 3);
      @(negedge clk);
      if (b == 0) chk("wo_aw1_id", 32'(slv_req.aw.id), 32'h11);
      chk("wo_m2_data", slv_req.w.data, 32'h200 + 32'(b));
      chk("wo_m1_wready_held", 32'(mst_resp[1].w_ready), 0);
      nxt();
      mst_req[1].aw_valid = 1'b0;
    end
    mst_req[2].w_valid = 1'b0;
    @(negedge clk);
    chk("wo_m1_data", slv_req.w.data, 32'h100);
    chk("wo_m1_wready", 32'(mst_resp[1].w_ready), 1);
    chk("wo_m1_last", 32'(slv_req.w.last), 1);
    nxt();
    mst_req[1].w_valid = 1'b0;
    slv_resp.b_valid = 1'b1;
    slv_resp.b.id    = 6'h11;
    @(negedge clk);
    chk("b_m1_valid", 32'(mst_resp[1].b_valid), 1);
    chk("b_m1_id", 32'(mst_resp[1].b.id), 32'h1);
    chk("b_m0_valid", 32'(mst_resp[0].b_valid), 0);
    chk("b_ready", 32'(slv_req.b_ready), 1);
    nxt();
    slv_resp.b_valid = 1'b0;

    // W queue depth 2: third AW waits for the first W last.
    do_reset();
    slv_resp.aw_ready = 1'b1;
    slv_resp.w_ready  = 1'b1;
    mst_req[0].aw_valid = 1'b1;
    nxt();
    mst_req[0].aw_valid = 1'b0;
    mst_req[1].aw_valid = 1'b1;
    nxt();
    mst_req[1].aw_valid = 1'b0;
    mst_req[2].aw_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("wq_full_aw_valid", 32'(slv_req.aw_valid), 0);
      chk("wq_full_aw_ready", 32'(mst_resp[2].aw_ready), 0);
      nxt();
    end
    mst_req[0].w_valid = 1'b1;
    mst_req[0].w.last  = 1'b1;
    @(negedge clk);
    chk("wq_pop_w_ready", 32'(mst_resp[0].w_ready), 1);
    chk("wq_pop_aw_still_0", 32'(mst_resp[2].aw_ready), 0);
    nxt();
    mst_req[0].w_valid = 1'b0;
    @(negedge clk);
    chk("wq_freed_aw_ready", 32'(mst_resp[2].aw_ready), 1);
    chk("wq_freed_aw_id", 32'(slv_req.aw.id), 32'h27);
    nxt();

    // Out-of-range B prefix.
    do_reset();
    slv_resp.b_valid = 1'b1;
    slv_resp.b.id    = 6'h32;
    @(negedge clk);
    chk("oor_b_ready", 32'(slv_req.b_ready), 1);
    for (int m = 0; m < CacheNumMst; m++) chk("oor_no_b_valid", 32'(mst_resp[m].b_valid), 0);
    chk("oor_err_before", 32'(route_err), 0);
    nxt();
    slv_resp.b_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("oor_err_sticky", 32'(route_err), 1);
      nxt();
    end
    do_reset();
    @(negedge clk);
    chk("oor_err_cleared", 32'(route_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
